// File: rtl/sd_resp_pkg.sv
// rtl/sd_resp_pkg.sv - shared state encoding and sector geometry for the sector-transfer responder
package sd_resp_pkg;

  localparam int SECTOR_WORDS = 256;
  localparam int WORD_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DELAY   = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_PUT  = 3'd3,
    ST_WR_ADDR = 3'd4,
    ST_WR_WAIT = 3'd5,
    ST_WR_REQ  = 3'd6,
    ST_DONE    = 3'd7
  } sd_resp_state_t;

endpackage

// File: rtl/bram_sd_responder.sv
// rtl/bram_sd_responder.sv - services one 256-word sector per sd_rd/sd_wr request against a word-addressed store
module bram_sd_responder
  import sd_resp_pkg::*;
#(
  parameter int LBA_W     = 7,
  parameter int ACK_DELAY = 4
) (
  input  logic              clk_sys,
  input  logic              RESET_N,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [7:0]        sd_buff_addr,
  output logic [WORD_W-1:0] sd_buff_dout,
  input  logic [WORD_W-1:0] sd_buff_din,
  output logic              sd_buff_wr,
  output logic [LBA_W+7:0]  mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [WORD_W-1:0] mem_din,
  input  logic [WORD_W-1:0] mem_dout,
  input  logic              mem_ack
);

  localparam int            CW        = $clog2(ACK_DELAY + 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'(ACK_DELAY - 1);
  localparam logic [7:0]    LAST_WORD = 8'(SECTOR_WORDS - 1);

  sd_resp_state_t    state_q, state_d;
  logic [7:0]        w_q, w_d;
  logic [CW-1:0]     dcnt_q, dcnt_d;
  logic [LBA_W-1:0]  lba_q, lba_d;
  logic              oor_q, oor_d;
  logic              is_rd_q, is_rd_d;
  logic [7:0]        addr_q, addr_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic [WORD_W-1:0] din_q, din_d;
  logic              step_ok;

  // Out-of-range sectors never touch the store, so each word completes at once.
  assign step_ok = oor_q | mem_ack;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    dcnt_d  = dcnt_q;
    lba_d   = lba_q;
    oor_d   = oor_q;
    is_rd_d = is_rd_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    din_d   = din_q;
    case (state_q)
      ST_IDLE: begin
        if (sd_rd | sd_wr) begin
          is_rd_d = sd_rd;
          lba_d   = sd_lba[LBA_W-1:0];
          oor_d   = |sd_lba[31:LBA_W];
          w_d     = 8'd0;
          dcnt_d  = '0;
          state_d = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (dcnt_q == DLY_LAST) begin
          if (is_rd_q) begin
            state_d = ST_RD_REQ;
          end else begin
            addr_d  = w_q;
            state_d = ST_WR_ADDR;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (step_ok) begin
          dout_d  = oor_q ? '0 : mem_dout;
          addr_d  = w_q;
          state_d = ST_RD_PUT;
        end
      end
      ST_RD_PUT: begin
        if (w_q == LAST_WORD) begin
          state_d = ST_DONE;
        end else begin
          w_d     = w_q + 8'd1;
          state_d = ST_RD_REQ;
        end
      end
      ST_WR_ADDR: state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        // Buffer RAM answers one cycle after the address, i.e. during this state.
        din_d   = sd_buff_din;
        state_d = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        if (step_ok) begin
          if (w_q == LAST_WORD) begin
            state_d = ST_DONE;
          end else begin
            w_d     = w_q + 8'd1;
            addr_d  = w_q + 8'd1;
            state_d = ST_WR_ADDR;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      w_q     <= 8'd0;
      dcnt_q  <= '0;
      lba_q   <= '0;
      oor_q   <= 1'b0;
      is_rd_q <= 1'b0;
      addr_q  <= 8'd0;
      dout_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      dcnt_q  <= dcnt_d;
      lba_q   <= lba_d;
      oor_q   <= oor_d;
      is_rd_q <= is_rd_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      din_q   <= din_d;
    end
  end

  assign sd_ack       = (state_q != ST_IDLE) && (state_q != ST_DELAY);
  assign sd_buff_wr   = (state_q == ST_RD_PUT);
  assign sd_buff_addr = addr_q;
  assign sd_buff_dout = dout_q;
  assign mem_addr     = {lba_q, w_q};
  assign mem_rd       = (state_q == ST_RD_REQ) && !oor_q;
  assign mem_wr       = (state_q == ST_WR_REQ) && !oor_q;
  assign mem_din      = din_q;

endmodule

// File: tb/tb_bram_sd_responder.sv
// tb/tb_bram_sd_responder.sv - directed self-checking bench for bram_sd_responder
`timescale 1ns/1ps
module tb_bram_sd_responder;

  localparam int LBA_W     = 7;
  localparam int ACK_DELAY = 4;
  localparam int AW        = LBA_W + 8;
  localparam int LOOP_N    = 16;

  logic          clk_sys = 1'b0;
  logic          RESET_N;
  logic [31:0]   sd_lba;
  logic          sd_rd, sd_wr;
  logic          sd_ack;
  logic [7:0]    sd_buff_addr;
  logic [15:0]   sd_buff_dout;
  logic [15:0]   sd_buff_din;
  logic          sd_buff_wr;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;
  logic [15:0]   mem_din, mem_dout;
  logic          mem_ack;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_sys = ~clk_sys;

  bram_sd_responder #(.LBA_W(LBA_W), .ACK_DELAY(ACK_DELAY)) dut (
    .clk_sys(clk_sys), .RESET_N(RESET_N), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack)
  );

  logic [AW+43:0] all_outs;
  assign all_outs = {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr, mem_rd, mem_wr, mem_din};

  // sd_mem_model: behavioural store with a programmable mem_ack wait count
  logic [15:0]   store [0:(1<<AW)-1];
  int            wait_n = 0;
  int            wcnt = 0;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [15:0]   pre_data = '0;
  assign mem_ack  = (mem_rd | mem_wr) && (wcnt == wait_n);
  assign mem_dout = store[mem_addr];
  always @(posedge clk_sys) begin
    if (pre_we) store[pre_addr] <= pre_data;
    if (mem_wr && mem_ack) store[mem_addr] <= mem_din;
    if ((mem_rd | mem_wr) && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // core buffer RAM with one-cycle read latency
  logic [15:0] bufram [0:255];
  always @(posedge clk_sys) sd_buff_din <= bufram[sd_buff_addr];

  logic [7:0]    st_addr[$];
  logic [15:0]   st_data[$];
  int            ack_cyc = 0, ack_rises = 0, rd_acks = 0, wr_acks = 0, rd_cyc = 0;
  int            bad_wr = 0, unstable = 0;
  logic          prev_ack = 1'b0, prev_bwr = 1'b0, prev_req = 1'b0, prev_mack = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [15:0]   prev_din = '0;
  always @(negedge clk_sys) begin
    if (sd_ack) ack_cyc <= ack_cyc + 1;
    if (sd_ack && !prev_ack) ack_rises <= ack_rises + 1;
    if (mem_rd) rd_cyc <= rd_cyc + 1;
    if (mem_rd && mem_ack) rd_acks <= rd_acks + 1;
    if (mem_wr && mem_ack) wr_acks <= wr_acks + 1;
    if (sd_buff_wr) begin
      st_addr.push_back(sd_buff_addr);
      st_data.push_back(sd_buff_dout);
      if (!sd_ack || prev_bwr) bad_wr <= bad_wr + 1;
    end
    if ((mem_rd | mem_wr) && prev_req && !prev_mack && (mem_addr !== prev_addr || mem_din !== prev_din))
      unstable <= unstable + 1;
    prev_ack  <= sd_ack;
    prev_bwr  <= sd_buff_wr;
    prev_req  <= mem_rd | mem_wr;
    prev_mack <= mem_ack;
    prev_addr <= mem_addr;
    prev_din  <= mem_din;
  end

  function automatic int strobe_errs(input int si, input logic [15:0] base, input bit zero);
    int e = 0;
    for (int k = 0; k < 256; k++) begin
      if (si + k >= st_addr.size()) e++;
      else if (st_addr[si+k] !== 8'(k) || st_data[si+k] !== (zero ? 16'h0000 : base + 16'(k))) e++;
    end
    return e;
  endfunction

  function automatic logic [15:0] loop_pat(input int s, input int k);
    return 16'((s << 8) | k) ^ 16'h5A5A;
  endfunction

  task automatic preload_sector(input int lba, input logic [15:0] base);
    for (int k = 0; k < 256; k++) begin
      pre_addr = AW'(lba * 256 + k);
      pre_data = base + 16'(k);
      pre_we   = 1'b1;
      @(negedge clk_sys);
    end
    pre_we = 1'b0;
  endtask

  task automatic do_xfer(input logic rd, input logic wr, input logic [31:0] lba, output int lat, output bit to);
    int n;
    to = 1'b0;
    sd_lba = lba;
    sd_rd = rd;
    sd_wr = wr;
    n = 0;
    while (!sd_ack && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    lat = n;
    if (!sd_ack) to = 1'b1;
    @(negedge clk_sys);
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    n = 0;
    while (sd_ack && n < 10000) begin
      @(negedge clk_sys);
      n++;
    end
    if (sd_ack) to = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    RESET_N = 1'b0; sd_rd = 1'b0; sd_wr = 1'b0; sd_lba = '0;
    repeat (3) @(negedge clk_sys);
    n_cmp++;
    if (all_outs !== '0) begin n_fail++; $display("FAIL reset_outs: got %h expected 0", all_outs); end
    RESET_N = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk_sys);
      if (all_outs !== '0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL idle_outs: %0d nonzero cycles, expected 0", bad); end
  endtask

  task automatic test_read_sector();
    int si, a0, r0, b0, u0, lat; bit to;
    @(negedge clk_sys);
    preload_sector(5, 16'h0500);
    si = st_addr.size(); a0 = ack_cyc; r0 = rd_acks; b0 = bad_wr; u0 = unstable;
    do_xfer(1'b1, 1'b0, 32'd5, lat, to);
    @(negedge clk_sys);
    n_cmp++; if (to) begin n_fail++; $display("FAIL rd_timeout: got 1 expected 0"); end
    n_cmp++; if (lat != ACK_DELAY + 1) begin n_fail++; $display("FAIL rd_ack_latency: got %0d expected %0d", lat, ACK_DELAY + 1); end
    n_cmp++; if (ack_cyc - a0 != 513) begin n_fail++; $display("FAIL rd_ack_cycles: got %0d expected 513", ack_cyc - a0); end
    n_cmp++; if (st_addr.size() - si != 256) begin n_fail++; $display("FAIL rd_strobes: got %0d expected 256", st_addr.size() - si); end
    n_cmp++; if (strobe_errs(si, 16'h0500, 1'b0) != 0) begin n_fail++; $display("FAIL rd_data: %0d bad words expected 0", strobe_errs(si, 16'h0500, 1'b0)); end
    n_cmp++; if (rd_acks - r0 != 256) begin n_fail++; $display("FAIL rd_mem_reads: got %0d expected 256", rd_acks - r0); end
    n_cmp++; if (bad_wr != b0) begin n_fail++; $display("FAIL rd_strobe_shape: got %0d bad expected 0", bad_wr - b0); end
    n_cmp++; if (unstable != u0) begin n_fail++; $display("FAIL rd_req_stable: got %0d changes expected 0", unstable - u0); end
  endtask

  task automatic test_write_sector();
    int si, a0, w0, lat, errs; bit to;
    @(negedge clk_sys);
    for (int k = 0; k < 256; k++) bufram[k] = ~16'(k);
    si = st_addr.size(); a0 = ack_cyc; w0 = wr_acks;
    do_xfer(1'b0, 1'b1, 32'd127, lat, to);
    @(negedge clk_sys);
    errs = 0;
    for (int k = 0; k < 256; k++) if (store[AW'(127 * 256 + k)] !== ~16'(k)) errs++;
    n_cmp++; if (to) begin n_fail++; $display("FAIL wr_timeout: got 1 expected 0"); end
    n_cmp++; if (lat != ACK_DELAY + 1) begin n_fail++; $display("FAIL wr_ack_latency: got %0d expected %0d", lat, ACK_DELAY + 1); end
    n_cmp++; if (ack_cyc - a0 != 769) begin n_fail++; $display("FAIL wr_ack_cycles: got %0d expected 769", ack_cyc - a0); end
    n_cmp++; if (st_addr.size() != si) begin n_fail++; $display("FAIL wr_no_strobe: got %0d strobes expected 0", st_addr.size() - si); end
    n_cmp++; if (wr_acks - w0 != 256) begin n_fail++; $display("FAIL wr_mem_writes: got %0d expected 256", wr_acks - w0); end
    n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL wr_store_data: %0d bad words expected 0", errs); end
  endtask

  task automatic test_initiator_loop();
    int r0, w0, tos, errs, lat; bit to;
    @(negedge clk_sys);
    r0 = ack_rises; w0 = wr_acks; tos = 0;
    for (int s = 0; s < LOOP_N; s++) begin
      for (int k = 0; k < 256; k++) bufram[k] = loop_pat(s, k);
      do_xfer(1'b0, 1'b1, 32'(s), lat, to);
      if (to) tos++;
    end
    @(negedge clk_sys);
    errs = 0;
    for (int s = 0; s < LOOP_N; s++)
      for (int k = 0; k < 256; k++) if (store[AW'(s * 256 + k)] !== loop_pat(s, k)) errs++;
    n_cmp++; if (tos != 0) begin n_fail++; $display("FAIL loop_timeouts: got %0d expected 0", tos); end
    n_cmp++; if (ack_rises - r0 != LOOP_N) begin n_fail++; $display("FAIL loop_transfers: got %0d expected %0d", ack_rises - r0, LOOP_N); end
    n_cmp++; if (wr_acks - w0 != LOOP_N * 256) begin n_fail++; $display("FAIL loop_writes: got %0d expected %0d", wr_acks - w0, LOOP_N * 256); end
    n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL loop_store_data: %0d bad words expected 0", errs); end
  endtask

  task automatic test_out_of_range();
    int si, a0, c0, w0, lat; bit to;
    @(negedge clk_sys);
    si = st_addr.size(); a0 = ack_cyc; c0 = rd_cyc;
    do_xfer(1'b1, 1'b0, 32'd128, lat, to);
    @(negedge clk_sys);
    n_cmp++; if (to) begin n_fail++; $display("FAIL oor_rd_timeout: got 1 expected 0"); end
    n_cmp++; if (st_addr.size() - si != 256) begin n_fail++; $display("FAIL oor_rd_strobes: got %0d expected 256", st_addr.size() - si); end
    n_cmp++; if (strobe_errs(si, 16'h0000, 1'b1) != 0) begin n_fail++; $display("FAIL oor_rd_zero: %0d bad words expected 0", strobe_errs(si, 16'h0000, 1'b1)); end
    n_cmp++; if (rd_cyc != c0) begin n_fail++; $display("FAIL oor_mem_rd: got %0d cycles expected 0", rd_cyc - c0); end
    n_cmp++; if (ack_cyc - a0 != 513) begin n_fail++; $display("FAIL oor_rd_ack_cycles: got %0d expected 513", ack_cyc - a0); end
    a0 = ack_cyc; w0 = wr_acks;
    do_xfer(1'b0, 1'b1, 32'h0000_0100, lat, to);
    @(negedge clk_sys);
    n_cmp++; if (wr_acks != w0) begin n_fail++; $display("FAIL oor_mem_wr: got %0d writes expected 0", wr_acks - w0); end
    n_cmp++; if (ack_cyc - a0 != 769) begin n_fail++; $display("FAIL oor_wr_ack_cycles: got %0d expected 769", ack_cyc - a0); end
  endtask

  task automatic test_both_requests();
    int si, w0, lat; bit to;
    @(negedge clk_sys);
    preload_sector(5, 16'h0500);
    si = st_addr.size(); w0 = wr_acks;
    do_xfer(1'b1, 1'b1, 32'd5, lat, to);
    @(negedge clk_sys);
    n_cmp++; if (st_addr.size() - si != 256) begin n_fail++; $display("FAIL both_strobes: got %0d expected 256", st_addr.size() - si); end
    n_cmp++; if (strobe_errs(si, 16'h0500, 1'b0) != 0) begin n_fail++; $display("FAIL both_data: %0d bad words expected 0", strobe_errs(si, 16'h0500, 1'b0)); end
    n_cmp++; if (wr_acks != w0) begin n_fail++; $display("FAIL both_no_write: got %0d writes expected 0", wr_acks - w0); end
  endtask

  task automatic test_wait_states();
    int si, a0, u0, lat; bit to;
    @(negedge clk_sys);
    wait_n = 3;
    si = st_addr.size(); a0 = ack_cyc; u0 = unstable;
    do_xfer(1'b1, 1'b0, 32'd5, lat, to);
    @(negedge clk_sys);
    wait_n = 0;
    n_cmp++; if (ack_cyc - a0 != 256 * 5 + 1) begin n_fail++; $display("FAIL wait_ack_cycles: got %0d expected %0d", ack_cyc - a0, 256 * 5 + 1); end
    n_cmp++; if (strobe_errs(si, 16'h0500, 1'b0) != 0) begin n_fail++; $display("FAIL wait_data: %0d bad words expected 0", strobe_errs(si, 16'h0500, 1'b0)); end
    n_cmp++; if (unstable != u0) begin n_fail++; $display("FAIL wait_req_stable: got %0d changes expected 0", unstable - u0); end
  endtask

  task automatic test_reset_abort();
    int n, si, lat; bit found, to;
    @(negedge clk_sys);
    sd_lba = 32'd5; sd_rd = 1'b1;
    found = 1'b0; n = 0;
    while (!found && n < 2000) begin
      @(negedge clk_sys);
      n++;
      if (sd_ack) sd_rd = 1'b0;
      if (sd_buff_wr && sd_buff_addr == 8'd100) found = 1'b1;
    end
    RESET_N = 1'b0; sd_rd = 1'b0;
    #1;
    n_cmp++; if (!found) begin n_fail++; $display("FAIL abort_reach_word100: got 0 expected 1"); end
    n_cmp++; if (all_outs !== '0) begin n_fail++; $display("FAIL abort_outs: got %h expected 0", all_outs); end
    @(negedge clk_sys);
    RESET_N = 1'b1;
    @(negedge clk_sys);
    si = st_addr.size();
    do_xfer(1'b1, 1'b0, 32'd5, lat, to);
    @(negedge clk_sys);
    n_cmp++; if (to || lat != ACK_DELAY + 1) begin n_fail++; $display("FAIL restart_latency: got %0d (timeout %0d) expected %0d", lat, to, ACK_DELAY + 1); end
    n_cmp++; if (st_addr.size() - si != 256) begin n_fail++; $display("FAIL restart_strobes: got %0d expected 256", st_addr.size() - si); end
    n_cmp++; if (strobe_errs(si, 16'h0500, 1'b0) != 0) begin n_fail++; $display("FAIL restart_data: %0d bad words expected 0", strobe_errs(si, 16'h0500, 1'b0)); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_sector();
    test_write_sector();
    test_initiator_loop();
    test_out_of_range();
    test_both_requests();
    test_wait_states();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
